// File: rtl/add_subt_arbiter.sv
// add_subt_arbiter: round-robin sharing of one add/subtract unit among three requesters
module add_subt_arbiter #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [2:0]     req_beg,
  input  logic [2:0]     req_op,
  input  logic [3*W-1:0] req_a,
  input  logic [3*W-1:0] req_b,
  input  logic [2:0]     req_ack,
  output logic [2:0]     req_ready,
  output logic [W-1:0]   result,
  output logic [1:0]     grant,
  output logic           busy,
  output logic           beg_add_subt,
  output logic           op_add_subt,
  output logic [W-1:0]   data_a,
  output logic [W-1:0]   data_b,
  input  logic           ready_add_subt,
  input  logic [W-1:0]   result_add_subt,
  output logic           ack_add_subt
);
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, CAPTURE, DELIVER} state_t;
  state_t         state_q;
  logic [1:0]     rr_q, grant_q, g_d, p1, p2;
  logic           busy_q, beg_q, ack_q, op_q, sel_op;
  logic [W-1:0]   a_q, b_q, res_q, sel_a, sel_b;
  logic [2:0]     rdy_q;
  always_comb begin
    p1 = (rr_q == 2'd2) ? 2'd0 : rr_q + 2'd1;
    p2 = (rr_q == 2'd0) ? 2'd2 : rr_q - 2'd1;
    g_d = req_beg[rr_q] ? rr_q : req_beg[p1] ? p1 : p2;
    sel_a = (grant_q == 2'd0) ? req_a[0+:W] : (grant_q == 2'd1) ? req_a[W+:W] : req_a[2*W+:W];
    sel_b = (grant_q == 2'd0) ? req_b[0+:W] : (grant_q == 2'd1) ? req_b[W+:W] : req_b[2*W+:W];
    sel_op = (grant_q == 2'd0) ? req_op[0] : (grant_q == 2'd1) ? req_op[1] : req_op[2];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= 2'd0;
      grant_q <= 2'b11;
      busy_q  <= 1'b0;
      beg_q   <= 1'b0;
      ack_q   <= 1'b0;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      rdy_q   <= 3'b000;
    end else begin
      case (state_q)
        IDLE: if (|req_beg) begin
          grant_q <= g_d;
          busy_q  <= 1'b1;
          state_q <= LOAD;
        end
        LOAD: begin
          a_q     <= sel_a;
          b_q     <= sel_b;
          op_q    <= sel_op;
          beg_q   <= 1'b1;
          state_q <= START;
        end
        START: begin
          beg_q   <= 1'b0;
          state_q <= WAIT;
        end
        // result is taken on the edge ready is seen so it is valid alongside the ack pulse
        WAIT: if (ready_add_subt) begin
          res_q   <= result_add_subt;
          ack_q   <= 1'b1;
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          ack_q   <= 1'b0;
          rdy_q   <= 3'b001 << grant_q;
          state_q <= DELIVER;
        end
        DELIVER: if (|(req_ack & rdy_q)) begin
          rdy_q   <= 3'b000;
          grant_q <= 2'b11;
          rr_q    <= (grant_q == 2'd2) ? 2'd0 : grant_q + 2'd1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign req_ready    = rdy_q;
  assign result       = res_q;
  assign grant        = grant_q;
  assign busy         = busy_q;
  assign beg_add_subt = beg_q;
  assign op_add_subt  = op_q;
  assign data_a       = a_q;
  assign data_b       = b_q;
  assign ack_add_subt = ack_q;
endmodule

// File: tb/tb_add_subt_arbiter.sv
// tb_add_subt_arbiter: directed scenarios against a behavioural add/subt unit
module tb_add_subt_arbiter;
  localparam int W = 32;
  logic clk = 0, reset = 1;
  logic [2:0] req_beg = 0, req_op = 0, req_ack = 0, req_ready;
  logic [3*W-1:0] req_a = 0, req_b = 0;
  logic [W-1:0] result, data_a, data_b, result_add_subt;
  logic [1:0] grant;
  logic busy, beg_add_subt, op_add_subt, ready_add_subt, ack_add_subt;
  logic m_rdy = 0, pend = 0, m_kill = 0, s_rdy = 0;
  int cnt = 0, m_dly = 2;
  logic [W-1:0] m_res = 0;
  int total = 0, bad = 0;

  add_subt_arbiter #(.W(W)) dut (
    .clk(clk), .reset(reset), .req_beg(req_beg), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ack(req_ack), .req_ready(req_ready), .result(result), .grant(grant), .busy(busy),
    .beg_add_subt(beg_add_subt), .op_add_subt(op_add_subt), .data_a(data_a), .data_b(data_b),
    .ready_add_subt(ready_add_subt), .result_add_subt(result_add_subt), .ack_add_subt(ack_add_subt)
  );

  always #5 clk = ~clk;
  assign ready_add_subt  = m_rdy | s_rdy;
  assign result_add_subt = m_res;

  // unit model: raises ready m_dly cycles after beg, holds it until ack
  always @(posedge clk) begin
    if (m_kill) begin m_rdy <= 0; pend <= 0; end
    else if (beg_add_subt) begin pend <= 1; cnt <= m_dly; end
    else if (pend) begin
      if (cnt <= 1) begin m_rdy <= 1; pend <= 0; end
      else cnt <= cnt - 1;
    end
    else if (ack_add_subt) m_rdy <= 0;
  end

  task test_reset;
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
    total++; if (grant !== 2'b11) begin bad++; $display("FAIL reset_grant got=%h want=3", grant); end
    total++; if (busy !== 0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (req_ready !== 0) begin bad++; $display("FAIL reset_ready got=%b want=000", req_ready); end
    total++; if ({beg_add_subt, ack_add_subt} !== 2'b00) begin bad++; $display("FAIL reset_beg_ack got=%b want=00", {beg_add_subt, ack_add_subt}); end
    total++; if (result !== 0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
  endtask

  task test_single;
    int n;
    @(negedge clk);
    req_a[W+:W] = 32'h40400000; req_b[W+:W] = 32'h3F800000; req_op = 3'b010;
    m_res = 32'h40000000; m_dly = 5; req_beg = 3'b010;
    @(negedge clk);
    total++; if (grant !== 2'd1 || busy !== 1) begin bad++; $display("FAIL single_grant got=%h/%b want=1/1", grant, busy); end
    total++; if (beg_add_subt !== 0) begin bad++; $display("FAIL single_beg_early got=%b want=0", beg_add_subt); end
    @(negedge clk);
    total++; if (beg_add_subt !== 1) begin bad++; $display("FAIL single_beg got=%b want=1", beg_add_subt); end
    total++; if (data_a !== 32'h40400000 || data_b !== 32'h3F800000 || op_add_subt !== 1)
      begin bad++; $display("FAIL single_operands got=%h %h %b want=40400000 3f800000 1", data_a, data_b, op_add_subt); end
    @(negedge clk);
    total++; if (beg_add_subt !== 0) begin bad++; $display("FAIL single_beg_pulse got=%b want=0", beg_add_subt); end
    n = 0; while (ack_add_subt !== 1 && n < 30) begin @(negedge clk); n++; end
    total++; if (ack_add_subt !== 1) begin bad++; $display("FAIL single_ack_timeout got=%b want=1", ack_add_subt); end
    total++; if (result !== 32'h40000000 || req_ready !== 0)
      begin bad++; $display("FAIL single_capture got=%h/%b want=40000000/000", result, req_ready); end
    @(negedge clk);
    total++; if (req_ready !== 3'b010 || ack_add_subt !== 0)
      begin bad++; $display("FAIL single_ready got=%b/%b want=010/0", req_ready, ack_add_subt); end
    repeat (3) @(negedge clk);
    total++; if (req_ready !== 3'b010 || result !== 32'h40000000)
      begin bad++; $display("FAIL single_hold got=%b/%h want=010/40000000", req_ready, result); end
    req_ack = 3'b010;
    @(negedge clk); req_ack = 0; req_beg = 0;
    total++; if (req_ready !== 0 || grant !== 2'b11 || busy !== 0)
      begin bad++; $display("FAIL single_release got=%b/%h/%b want=000/3/0", req_ready, grant, busy); end
  endtask

  task test_contention;
    logic [1:0] exp_g, exp_rr;
    int n;
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
    req_a = {32'hC, 32'hB, 32'hA}; req_b = {32'h3, 32'h2, 32'h1};
    m_dly = 2; req_ack = 3'b111; req_beg = 3'b111;
    for (int i = 0; i < 4; i++) begin
      exp_g = 2'(i % 3); exp_rr = 2'((i + 1) % 3); m_res = 32'h100 + i;
      n = 0; while (grant === 2'b11 && n < 10) begin @(negedge clk); n++; end
      total++; if (grant !== exp_g) begin bad++; $display("FAIL rr_grant%0d got=%h want=%h", i, grant, exp_g); end
      n = 0; while (req_ready === 0 && n < 30) begin @(negedge clk); n++; end
      total++; if (req_ready !== (3'b001 << exp_g) || result !== m_res || data_a !== req_a[int'(exp_g)*W+:W])
        begin bad++; $display("FAIL rr_deliver%0d got=%b/%h/%h want=%b/%h/%h", i, req_ready, result, data_a,
          3'b001 << exp_g, m_res, req_a[int'(exp_g)*W+:W]); end
      if (i == 3) req_beg = 0;
      @(negedge clk);
      total++; if (req_ready !== 0 || grant !== 2'b11 || dut.rr_q !== exp_rr)
        begin bad++; $display("FAIL rr_ptr%0d got=%b/%h/%h want=000/3/%h", i, req_ready, grant, dut.rr_q, exp_rr); end
    end
    req_ack = 0;
  endtask

  task test_withdraw;
    int n;
    req_a[0+:W] = 32'h11111111; req_b[0+:W] = 32'h22222222; req_op = 0;
    m_res = 32'h33333333; m_dly = 3; req_beg = 3'b001;
    n = 0; while (beg_add_subt !== 1 && n < 10) begin @(negedge clk); n++; end
    total++; if (beg_add_subt !== 1) begin bad++; $display("FAIL wd_beg_timeout got=%b want=1", beg_add_subt); end
    @(negedge clk);
    req_beg = 0; req_a[0+:W] = 32'hDEADBEEF; req_op = 3'b001;
    n = 0; while (req_ready === 0 && n < 30) begin @(negedge clk); n++; end
    total++; if (req_ready !== 3'b001 || result !== 32'h33333333)
      begin bad++; $display("FAIL wd_ready got=%b/%h want=001/33333333", req_ready, result); end
    total++; if (data_a !== 32'h11111111 || op_add_subt !== 0)
      begin bad++; $display("FAIL wd_latched got=%h/%b want=11111111/0", data_a, op_add_subt); end
    req_ack = 3'b001;
    @(negedge clk); req_ack = 0;
    total++; if (req_ready !== 0 || busy !== 0) begin bad++; $display("FAIL wd_release got=%b/%b want=000/0", req_ready, busy); end
  endtask

  task test_reset_wait;
    int n;
    logic seen;
    req_a[0+:W] = 32'h1; m_res = 32'h55555555; m_dly = 3; req_beg = 3'b001;
    n = 0; while (beg_add_subt !== 1 && n < 10) begin @(negedge clk); n++; end
    total++; if (beg_add_subt !== 1) begin bad++; $display("FAIL rw_beg_timeout got=%b want=1", beg_add_subt); end
    @(negedge clk); reset = 1; req_beg = 0;
    @(negedge clk); reset = 0;
    total++; if (busy !== 0 || grant !== 2'b11) begin bad++; $display("FAIL rw_cleared got=%b/%h want=0/3", busy, grant); end
    seen = 0;
    repeat (10) begin @(negedge clk); if (ack_add_subt || req_ready != 0 || busy) seen = 1; end
    total++; if (seen !== 0 || result !== 0) begin bad++; $display("FAIL rw_abandoned got=%b/%h want=0/0", seen, result); end
    m_kill = 1; @(negedge clk); m_kill = 0;
    req_a[2*W+:W] = 32'h40A00000; m_res = 32'h41200000; m_dly = 2; req_beg = 3'b100;
    @(negedge clk);
    total++; if (grant !== 2'd2) begin bad++; $display("FAIL rw_grant got=%h want=2", grant); end
    n = 0; while (req_ready === 0 && n < 30) begin @(negedge clk); n++; end
    total++; if (req_ready !== 3'b100 || result !== 32'h41200000 || data_a !== 32'h40A00000)
      begin bad++; $display("FAIL rw_serve got=%b/%h/%h want=100/41200000/40a00000", req_ready, result, data_a); end
    req_ack = 3'b100; req_beg = 0;
    @(negedge clk); req_ack = 0;
    total++; if (req_ready !== 0) begin bad++; $display("FAIL rw_release got=%b want=000", req_ready); end
  endtask

  task test_stray;
    int n;
    req_ack = 3'b111;
    @(negedge clk); s_rdy = 1;
    @(negedge clk); s_rdy = 0;
    total++; if (busy !== 0 || grant !== 2'b11 || ack_add_subt !== 0 || req_ready !== 0)
      begin bad++; $display("FAIL stray_idle got=%b/%h/%b/%b want=0/3/0/000", busy, grant, ack_add_subt, req_ready); end
    m_res = 32'h77; m_dly = 2; req_beg = 3'b010;
    @(negedge clk);
    total++; if (grant !== 2'd1) begin bad++; $display("FAIL stray_grant got=%h want=1", grant); end
    n = 0; while (req_ready === 0 && n < 30) begin @(negedge clk); n++; end
    total++; if (req_ready !== 3'b010 || result !== 32'h77)
      begin bad++; $display("FAIL stray_ready got=%b/%h want=010/77", req_ready, result); end
    req_beg = 0;
    @(negedge clk);
    total++; if (req_ready !== 0 || grant !== 2'b11) begin bad++; $display("FAIL stray_clear got=%b/%h want=000/3", req_ready, grant); end
    req_ack = 0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_contention;
    test_withdraw;
    test_reset_wait;
    test_stray;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
